uart_xcvr_param: RTL and testbench
==================================

Name: uart_xcvr_param

Overview:
- Parametrised single-channel UART transceiver; next generation of the fixed 8N1, 16-clocks-per-bit transmitter/receiver pair used by the dual-channel UART echo top.
- Adds configurable bit timing, data width, parity and stop bits.
- Adds a valid/ready TX interface, an RX FIFO with first-word fall-through, and sticky framing, parity and overrun error flags.
- Instantiated once per channel by the UART top level, replacing the separate TX and RX blocks.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, minimum 4.
- DATA_BITS, 8, payload bits per frame; 5..8, sent LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted (1 or 2); receiver checks only the first.
- FIFO_DEPTH, 4, RX FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock.
- rstn  in  1  reset; asynchronous, active-low. Every flop, including the RX synchroniser, resets on it.
- rxd  in  1  serial input; asynchronous to clk, idles high.
- txd  out  1  serial output; idles high.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a byte.
- tx_busy  out  1  a frame is in progress.
- rx_data  out  DATA_BITS  head of the RX FIFO.
- rx_valid  out  1  RX FIFO is non-empty.
- rx_ready  in  1  pops the FIFO head when rx_valid is high.
- rx_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- rx_frame_err  out  1  sticky framing error.
- rx_parity_err  out  1  sticky parity error.
- rx_overrun  out  1  sticky overrun.
- err_clr  in  1  single-cycle pulse; clears all three sticky flags.

Behaviour:
- Reset values: txd=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_level=0, rx_data=0, all error flags 0. Both FSMs reset to IDLE.
- Asserting rstn low mid-frame aborts the frame immediately: txd=1 and the FIFO is emptied.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Accept occurs when tx_valid & tx_ready; tx_data is latched on that cycle.
  - txd goes low on the next cycle. Each bit is held exactly CLKS_PER_BIT cycles.
  - Bit order: start(0), DATA_BITS data bits LSB first, parity (only if PARITY != 0), STOP_BITS stop bits(1).
  - tx_ready is high only in IDLE.
  - The FSM returns to IDLE on the final cycle of the last stop bit. With tx_valid held high, the next start bit follows with zero idle cycles.
  - Odd parity: data XOR parity bit = 1. Even parity: data XOR parity bit = 0.
  - tx_busy = !tx_ready.
- RX synchronisation: 2-flop synchroniser on rxd; all RX timing is measured from the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE -> START when the synchronised rxd is low.
  - In START, rxd is re-sampled after CLKS_PER_BIT/2 cycles. If it is high, the low was a glitch and the FSM returns to IDLE with no flag set.
  - Each later bit is sampled every CLKS_PER_BIT cycles from the start mid-point.
  - In STOP, the FSM samples the first stop bit at its mid-point:
    - Sample = 1: the byte is pushed on that cycle, and the FSM goes to IDLE in the same cycle so it can resynchronise to the next start edge.
    - Sample = 0: rx_frame_err is set, the byte is discarded, and the FSM enters BREAK.
  - BREAK -> IDLE only after the synchronised rxd is seen high.
  - A parity mismatch sets rx_parity_err; the byte is still pushed.
- FIFO:
  - rx_data is the head entry, valid in the same cycle rx_valid is high.
  - A pop occurs when rx_valid & rx_ready.
  - Push while full with no pop: the byte is dropped and rx_overrun is set.
  - Push and pop in the same cycle while full: both succeed, level is unchanged, no overrun.
  - Push and pop in the same cycle while empty: the push is stored and rx_valid goes high on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. rx_level ranges 0..FIFO_DEPTH.
- Sticky flags: each is cleared by err_clr. If a new error event occurs in the same cycle as err_clr, the event wins and the flag remains 1.
- Bit-period counters are log2-sized from CLKS_PER_BIT and saturate in no state.

Test Plan:
- 8N1, CLKS_PER_BIT=16; send tx_data=0xA5 -> txd=0 for 16 cycles starting the cycle after accept, then bits 1,0,1,0,0,1,0,1, then stop; tx_ready high again 160 cycles after accept.
- Loop txd to rxd, PARITY=2, send 0x3C then 0xC3 back-to-back -> no idle gap between frames; rx_data 0x3C then 0xC3; rx_parity_err=0; rx_level peaks at 2 with rx_ready=0.
- Drive rxd low for 6 cycles only (CLKS_PER_BIT=16) -> no push, no flags set, RX FSM back in IDLE.
- Frame 0x55 with the stop bit forced to 0, line held low 40 cycles then released -> rx_frame_err=1, FIFO empty; next valid frame 0x12 is received correctly.
- FIFO_DEPTH=4, rx_ready=0, send 5 frames -> rx_level=4, rx_overrun=1, the first four bytes are retained in order; err_clr pulse -> all flags 0.
- PARITY=1, inject a frame with a flipped parity bit on data 0x01 -> byte 0x01 pushed and rx_parity_err=1; assert rstn low mid-frame -> txd=1, rx_level=0, all flags 0.

Source files
------------

// File: rtl/uart_xcvr_param.sv
// Parametrised UART transceiver: valid/ready TX, first-word-fall-through RX FIFO, sticky error flags.
// TX start bit begins the cycle after accept; RX bytes are pushed at the first stop-bit mid-point.
module uart_xcvr_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        rxd,
  output logic                        txd,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_busy,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        rx_frame_err,
  output logic                        rx_parity_err,
  output logic                        rx_overrun,
  input  logic                        err_clr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_IDX  = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  // ---------------- transmitter ----------------
  logic [2:0]           tx_state;
  logic [2:0]           tx_idx;
  logic [CW-1:0]        tx_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt == BIT_LAST);
  assign tx_ready   = (tx_state == S_IDLE);
  assign tx_busy    = ~tx_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= S_IDLE;
      tx_idx   <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_cnt <= (tx_state == S_IDLE || tx_bit_end) ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        S_IDLE: if (tx_valid) begin
          tx_shift <= tx_data;
          tx_par   <= (^tx_data) ^ PAR_ODD;
          tx_state <= S_START;
        end
        S_START: if (tx_bit_end) begin
          tx_idx   <= '0;
          tx_state <= S_DATA;
        end
        S_DATA: if (tx_bit_end) begin
          tx_shift <= tx_shift >> 1;
          tx_idx   <= tx_idx + 1'b1;
          if (tx_idx == DATA_LAST) begin
            tx_idx   <= '0;
            tx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: if (tx_bit_end) begin
          tx_idx   <= '0;
          tx_state <= S_STOP;
        end
        // The last stop cycle is spent in IDLE so a queued byte starts with no gap.
        S_STOP: begin
          if (tx_idx == STOP_IDX && tx_cnt == STOP_LAST) tx_state <= S_IDLE;
          else if (tx_bit_end)                           tx_idx   <= tx_idx + 1'b1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (tx_state)
      S_START:  txd = 1'b0;
      S_DATA:   txd = tx_shift[0];
      S_PARITY: txd = tx_par;
      default:  txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic                 rx_s1, rx_s2;
  logic [2:0]           rx_state;
  logic [2:0]           rx_idx;
  logic [CW-1:0]        rx_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_bit_end, rx_restart;
  logic                 rx_push, par_evt, frame_evt;

  assign rx_bit_end = (rx_cnt == BIT_LAST);
  assign rx_restart = (rx_state == S_IDLE) || (rx_state == S_BREAK) ||
                      ((rx_state == S_START) ? (rx_cnt == HALF_LAST) : rx_bit_end);
  assign rx_push    = (rx_state == S_STOP) && rx_bit_end && rx_s2;
  assign frame_evt  = (rx_state == S_STOP) && rx_bit_end && !rx_s2;
  assign par_evt    = (rx_state == S_PARITY) && rx_bit_end && ((^rx_shift) ^ rx_s2 ^ PAR_ODD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= S_IDLE;
      rx_idx   <= '0;
      rx_cnt   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1  <= rxd;
      rx_s2  <= rx_s1;
      rx_cnt <= rx_restart ? '0 : rx_cnt + 1'b1;
      case (rx_state)
        S_IDLE:  if (!rx_s2) rx_state <= S_START;
        S_START: if (rx_cnt == HALF_LAST) begin
          rx_idx   <= '0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_bit_end) begin
          rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
          rx_idx   <= rx_idx + 1'b1;
          if (rx_idx == DATA_LAST) rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: if (rx_bit_end) rx_state <= S_STOP;
        S_STOP:   if (rx_bit_end) rx_state <= rx_s2 ? S_IDLE : S_BREAK;
        S_BREAK:  if (rx_s2) rx_state <= S_IDLE;
        default:  rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 fifo_full, do_push, do_pop, ovr_evt;

  assign rx_valid  = (rx_level != '0);
  assign fifo_full = (rx_level == FULL_LVL);
  assign do_pop    = rx_valid & rx_ready;
  assign do_push   = rx_push & (~fifo_full | do_pop);
  assign ovr_evt   = rx_push & fifo_full & ~do_pop;
  assign rx_data   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rx_level      <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= rx_shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   rx_level <= rx_level + 1'b1;
        2'b01:   rx_level <= rx_level - 1'b1;
        default: ;
      endcase
      // A new event in the clear cycle keeps the flag set.
      rx_frame_err  <= frame_evt | (rx_frame_err  & ~err_clr);
      rx_parity_err <= par_evt   | (rx_parity_err & ~err_clr);
      rx_overrun    <= ovr_evt   | (rx_overrun    & ~err_clr);
    end
  end
endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed bench for uart_xcvr_param: 8N1 instance (a), looped even-parity instance (b), odd-parity instance (c).
module tb_uart_xcvr_param;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic err_clr = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic       rxd_a = 1'b1, txd_a, tx_valid_a = 1'b0, tx_ready_a, tx_busy_a;
  logic       rx_valid_a, rx_ready_a = 1'b0, fe_a, pe_a, ov_a;
  logic [7:0] tx_data_a = 8'h00, rx_data_a;
  logic [2:0] rx_level_a;

  logic       txd_b, tx_valid_b = 1'b0, tx_ready_b, tx_busy_b;
  logic       rx_valid_b, rx_ready_b = 1'b0, fe_b, pe_b, ov_b;
  logic [7:0] tx_data_b = 8'h00, rx_data_b;
  logic [2:0] rx_level_b;

  logic       rxd_c = 1'b1, txd_c, tx_valid_c = 1'b0, tx_ready_c, tx_busy_c;
  logic       rx_valid_c, rx_ready_c = 1'b0, fe_c, pe_c, ov_c;
  logic [7:0] tx_data_c = 8'h00, rx_data_c;
  logic [2:0] rx_level_c;

  uart_xcvr_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rstn(rstn), .rxd(rxd_a), .txd(txd_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_busy(tx_busy_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_level(rx_level_a),
    .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ov_a), .err_clr(err_clr));

  uart_xcvr_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rstn(rstn), .rxd(txd_b), .txd(txd_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_busy(tx_busy_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_level(rx_level_b),
    .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ov_b), .err_clr(err_clr));

  uart_xcvr_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rstn(rstn), .rxd(rxd_c), .txd(txd_c),
    .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .tx_busy(tx_busy_c),
    .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c), .rx_level(rx_level_c),
    .rx_frame_err(fe_c), .rx_parity_err(pe_c), .rx_overrun(ov_c), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a serial level on instance a (sel 0) or c (sel 1) for n cycles; called on a negedge.
  task automatic set_rx(input int sel, input logic v, input int n);
    if (sel == 0) rxd_a = v;
    else          rxd_c = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic ser_frame(input int sel, input logic [7:0] d, input int par_mode,
                           input logic par_flip, input logic stop_v);
    set_rx(sel, 1'b0, 16);
    for (int i = 0; i < 8; i++) set_rx(sel, d[i], 16);
    if (par_mode != 0) set_rx(sel, (^d) ^ (par_mode == 1) ^ par_flip, 16);
    set_rx(sel, stop_v, 16);
  endtask

  task automatic pop_a(input string tag, input logic [7:0] exp);
    chk({tag, "_vld"}, rx_valid_a, 1);
    chk({tag, "_dat"}, rx_data_a, exp);
    rx_ready_a = 1'b1;
    @(negedge clk);
    rx_ready_a = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    int         b, gap, peak;

    repeat (3) @(negedge clk);
    chk("rst_txd", txd_a, 1);
    chk("rst_tx_ready", tx_ready_a, 1);
    chk("rst_tx_busy", tx_busy_a, 0);
    chk("rst_rx_valid", rx_valid_a, 0);
    chk("rst_rx_level", rx_level_a, 0);
    chk("rst_rx_data", rx_data_a, 0);
    chk("rst_flags", {fe_a, pe_a, ov_a}, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 transmit of 0xA5: check first and last cycle of every bit
    d = 8'hA5;
    tx_data_a = d;
    tx_valid_a = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid_a = 1'b0;
      b = (k - 1) / 16;
      if (b == 0)      e = 1'b0;
      else if (b <= 8) e = d[b-1];
      else             e = 1'b1;
      if ((k - 1) % 16 == 0 || (k - 1) % 16 == 15) chk($sformatf("tx_bit%0d_k%0d", b, k), txd_a, e);
      if (k == 159) begin
        chk("tx_ready_k159", tx_ready_a, 0);
        chk("tx_busy_k159", tx_busy_a, 1);
      end
      if (k == 160) chk("tx_ready_k160", tx_ready_a, 1);
    end

    // Looped even-parity back-to-back 0x3C, 0xC3
    tx_data_b = 8'h3C;
    tx_valid_b = 1'b1;
    gap = 0;
    for (int k = 1; k <= 300 && gap == 0; k++) begin
      @(negedge clk);
      if (k == 1) tx_data_b = 8'hC3;
      if (tx_ready_b) gap = k;
    end
    chk("b2b_ready_gap", gap, 176);
    @(negedge clk);
    tx_valid_b = 1'b0;
    chk("b2b_no_idle_txd", txd_b, 0);
    chk("b2b_busy", tx_busy_b, 1);
    peak = 0;
    repeat (220) begin
      @(negedge clk);
      if (rx_level_b > peak) peak = rx_level_b;
    end
    chk("b2b_peak", peak, 2);
    chk("b2b_head0", rx_data_b, 8'h3C);
    chk("b2b_par_err", pe_b, 0);
    chk("b2b_frm_err", fe_b, 0);
    rx_ready_b = 1'b1;
    @(negedge clk);
    rx_ready_b = 1'b0;
    chk("b2b_head1", rx_data_b, 8'hC3);
    chk("b2b_level1", rx_level_b, 1);
    rx_ready_b = 1'b1;
    @(negedge clk);
    rx_ready_b = 1'b0;
    chk("b2b_level0", rx_level_b, 0);
    chk("b2b_valid0", rx_valid_b, 0);

    // Start-bit glitch of 6 cycles, then a clean frame
    set_rx(0, 1'b0, 6);
    set_rx(0, 1'b1, 30);
    chk("glitch_level", rx_level_a, 0);
    chk("glitch_flags", {fe_a, pe_a, ov_a}, 0);
    ser_frame(0, 8'h5A, 0, 1'b0, 1'b1);
    set_rx(0, 1'b1, 20);
    pop_a("glitch_next", 8'h5A);

    // Framing error with a held break, then recovery
    ser_frame(0, 8'h55, 0, 1'b0, 1'b0);
    set_rx(0, 1'b0, 24);
    set_rx(0, 1'b1, 20);
    chk("brk_frame_err", fe_a, 1);
    chk("brk_fifo_empty", rx_valid_a, 0);
    ser_frame(0, 8'h12, 0, 1'b0, 1'b1);
    set_rx(0, 1'b1, 20);
    pop_a("brk_next", 8'h12);
    chk("brk_sticky", fe_a, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("brk_cleared", fe_a, 0);

    // Overrun: five frames into a depth-4 FIFO
    for (int i = 0; i < 5; i++) begin
      ser_frame(0, 8'(8'h11 * (i + 1)), 0, 1'b0, 1'b1);
      set_rx(0, 1'b1, 4);
    end
    set_rx(0, 1'b1, 16);
    chk("ovr_level", rx_level_a, 4);
    chk("ovr_flag", ov_a, 1);
    for (int i = 0; i < 4; i++) pop_a($sformatf("ovr_pop%0d", i), 8'(8'h11 * (i + 1)));
    chk("ovr_level0", rx_level_a, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovr_flags_clr", {fe_a, pe_a, ov_a}, 0);

    // Odd parity with flipped parity bit, then reset mid-frame
    ser_frame(1, 8'h01, 1, 1'b1, 1'b1);
    set_rx(1, 1'b1, 20);
    chk("par_level", rx_level_c, 1);
    chk("par_data", rx_data_c, 8'h01);
    chk("par_err", pe_c, 1);
    chk("par_frm_ok", fe_c, 0);
    tx_data_c = 8'h00;
    tx_valid_c = 1'b1;
    @(negedge clk);
    tx_valid_c = 1'b0;
    set_rx(1, 1'b0, 30);
    chk("mid_txd_low", txd_c, 0);
    rstn = 1'b0;
    #1;
    chk("rst_mid_txd", txd_c, 1);
    chk("rst_mid_level", rx_level_c, 0);
    chk("rst_mid_flags", {fe_c, pe_c, ov_c}, 0);
    chk("rst_mid_ready", tx_ready_c, 1);
    @(negedge clk);
    rxd_c = 1'b1;
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
